// File: rtl/tof_pulse_timer_pkg.sv
// Shared definitions for the time-of-flight pulse timer: FSM encoding, default sizes and
// the GPIO read-bus packing used by the board toplevel.
package tof_pulse_timer_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        FIRE = 2'd1,
        WAIT = 2'd2
    } tof_state_e;

    localparam int unsigned DEF_CNT_WIDTH = 16;
    localparam int unsigned DEF_MAX_COUNT = 65535;

    localparam int unsigned GPIO_COUNT_LSB   = 0;
    localparam int unsigned GPIO_COUNT_MSB   = 15;
    localparam int unsigned GPIO_VALID_BIT   = 16;
    localparam int unsigned GPIO_TIMEOUT_BIT = 17;
    localparam int unsigned GPIO_BUSY_BIT    = 18;

    function automatic logic [31:0] pack_gpio(input logic [DEF_CNT_WIDTH-1:0] count,
                                              input logic valid,
                                              input logic timeout,
                                              input logic busy);
        logic [31:0] w_word;
        w_word = '0;
        w_word[GPIO_COUNT_MSB:GPIO_COUNT_LSB] = count;
        w_word[GPIO_VALID_BIT]   = valid;
        w_word[GPIO_TIMEOUT_BIT] = timeout;
        w_word[GPIO_BUSY_BIT]    = busy;
        return w_word;
    endfunction

endpackage

// File: rtl/tof_pulse_timer_if.sv
// Control/status bundle between the SoC GPIO buses, the photodetector and the timer.
interface tof_pulse_timer_if
    import tof_pulse_timer_pkg::*;
#(
    parameter int unsigned CNT_WIDTH = DEF_CNT_WIDTH
);
    logic                 io_start;
    logic                 io_echo;
    logic                 io_laser_pulse;
    logic                 io_busy;
    logic                 io_valid;
    logic                 io_timeout;
    logic [CNT_WIDTH-1:0] io_count;

    modport master (
        output io_start,
        output io_echo,
        input  io_laser_pulse,
        input  io_busy,
        input  io_valid,
        input  io_timeout,
        input  io_count
    );

    modport slave (
        input  io_start,
        input  io_echo,
        output io_laser_pulse,
        output io_busy,
        output io_valid,
        output io_timeout,
        output io_count
    );
endinterface

// File: rtl/sync_rise_detect.sv
// Multi-flop synchronizer for an asynchronous level followed by a one-cycle rising-edge pulse.
module sync_rise_detect #(
    parameter int unsigned STAGES = 2
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_async,
    output logic o_rise
);
    logic [STAGES-1:0] r_sync;
    logic              r_last;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_sync <= '0;
            r_last <= 1'b0;
        end else begin
            r_sync <= {r_sync[STAGES-2:0], i_async};
            r_last <= r_sync[STAGES-1];
        end
    end

    assign o_rise = r_sync[STAGES-1] & ~r_last;
endmodule

// File: rtl/tof_pulse_timer.sv
// Fires a laser pulse on a start rising edge and counts clock cycles until the synchronized
// echo edge (outside the blanking window) or until the timeout count is reached.
module tof_pulse_timer
    import tof_pulse_timer_pkg::*;
#(
    parameter int unsigned CNT_WIDTH    = DEF_CNT_WIDTH,
    parameter int unsigned PULSE_LEN    = 4,
    parameter int unsigned BLANK_CYCLES = 8,
    parameter int unsigned MAX_COUNT    = DEF_MAX_COUNT,
    parameter int unsigned SYNC_STAGES  = 2
) (
    input logic               io_mainClk,
    input logic               io_asyncResetn,
    tof_pulse_timer_if.slave  bus
);
    localparam logic [CNT_WIDTH-1:0] MAX_C      = CNT_WIDTH'(MAX_COUNT);
    localparam logic [CNT_WIDTH-1:0] BLANK_C    = CNT_WIDTH'(BLANK_CYCLES);
    localparam logic [CNT_WIDTH-1:0] PULSE_LAST = CNT_WIDTH'(PULSE_LEN - 1);

    tof_state_e           r_state, w_state_d;
    logic [CNT_WIDTH-1:0] r_cnt, w_cnt_d;
    logic [CNT_WIDTH-1:0] r_count, w_count_d;
    logic                 r_laser, w_laser_d;
    logic                 r_busy, w_busy_d;
    logic                 r_valid, w_valid_d;
    logic                 r_timeout, w_timeout_d;
    logic                 r_start_d;

    logic                 w_start_rise;
    logic                 w_echo_rise;
    logic                 w_echo_hit;
    logic [CNT_WIDTH-1:0] w_cnt_inc;

    sync_rise_detect #(
        .STAGES (SYNC_STAGES)
    ) u_echo_sync (
        .i_clk   (io_mainClk),
        .i_rst_n (io_asyncResetn),
        .i_async (bus.io_echo),
        .o_rise  (w_echo_rise)
    );

    assign w_start_rise = bus.io_start & ~r_start_d;
    assign w_echo_hit   = w_echo_rise & (r_cnt >= BLANK_C);
    // Saturate rather than wrap so a missed timeout can never alias to a short range.
    assign w_cnt_inc    = (r_cnt == MAX_C) ? r_cnt : r_cnt + CNT_WIDTH'(1);

    always_comb begin
        w_state_d   = r_state;
        w_cnt_d     = r_cnt;
        w_count_d   = r_count;
        w_laser_d   = r_laser;
        w_busy_d    = r_busy;
        w_valid_d   = r_valid;
        w_timeout_d = r_timeout;
        unique case (r_state)
            IDLE: begin
                if (w_start_rise) begin
                    w_state_d   = FIRE;
                    w_cnt_d     = '0;
                    w_laser_d   = 1'b1;
                    w_busy_d    = 1'b1;
                    w_valid_d   = 1'b0;
                    w_timeout_d = 1'b0;
                end
            end
            FIRE, WAIT: begin
                w_cnt_d = w_cnt_inc;
                if (r_state == FIRE && r_cnt == PULSE_LAST) begin
                    w_laser_d = 1'b0;
                    w_state_d = WAIT;
                end
                // A qualifying echo on the timeout cycle still counts as a real echo.
                if (w_echo_hit) begin
                    w_count_d = r_cnt;
                    w_valid_d = 1'b1;
                    w_busy_d  = 1'b0;
                    w_laser_d = 1'b0;
                    w_state_d = IDLE;
                end else if (r_cnt == MAX_C) begin
                    w_count_d   = MAX_C;
                    w_timeout_d = 1'b1;
                    w_valid_d   = 1'b1;
                    w_busy_d    = 1'b0;
                    w_laser_d   = 1'b0;
                    w_state_d   = IDLE;
                end
            end
            default: w_state_d = IDLE;
        endcase
    end

    always_ff @(posedge io_mainClk or negedge io_asyncResetn) begin
        if (!io_asyncResetn) begin
            r_state   <= IDLE;
            r_cnt     <= '0;
            r_count   <= '0;
            r_laser   <= 1'b0;
            r_busy    <= 1'b0;
            r_valid   <= 1'b0;
            r_timeout <= 1'b0;
            r_start_d <= 1'b1;  // a start held through reset must not fire
        end else begin
            r_state   <= w_state_d;
            r_cnt     <= w_cnt_d;
            r_count   <= w_count_d;
            r_laser   <= w_laser_d;
            r_busy    <= w_busy_d;
            r_valid   <= w_valid_d;
            r_timeout <= w_timeout_d;
            r_start_d <= bus.io_start;
        end
    end

    assign bus.io_laser_pulse = r_laser;
    assign bus.io_busy        = r_busy;
    assign bus.io_valid       = r_valid;
    assign bus.io_timeout     = r_timeout;
    assign bus.io_count       = r_count;
endmodule
